mips_reg_file_mp: RTL and testbench
===================================

Name: mips_reg_file_mp

Overview:
- Parametrised multi-port successor to the core's 2R/1W register file.
- Provides NUM_RD combinational read ports and two synchronous write ports:
  - port 0: ALU writeback.
  - port 1: late writeback for loads and multi-cycle ops.
- Adds a per-register pending scoreboard so the hazard unit can stall on registers whose late result has not yet returned.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers (power of 2, ≥2).
- NUM_RD, 2, number of read ports (1..4).
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- we0  input  1  write enable, port 0.
- wa0  input  AW  write address, port 0.
- wd0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1 (late writeback); also clears pending.
- wa1  input  AW  write address, port 1.
- wd1  input  DW  write data, port 1.
- rsv_en  input  1  reserve request: mark rsv_addr pending.
- rsv_addr  input  AW  register to reserve.
- ra  input  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd  output  NUM_RD*DW  packed read data; port i at [i*DW +: DW].
- rd_pending  output  NUM_RD  pending bit of the register addressed by port i.
- any_pending  output  1  OR of all pending bits.

Behaviour:
- Storage:
  - DEPTH×DW register array; register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0; rd_pending is 0 for address 0.
- Reset:
  - When rst is high at a clock edge, all registers and all pending bits clear to 0.
  - Reset has priority over every write and reserve in that cycle.
  - After reset: rd = 0 on all ports, rd_pending = 0, any_pending = 0.
- Write:
  - Takes effect at the rising edge; data is visible on rd from the following cycle (same-cycle forwarding only under the optional feature).
- Dual write, same nonzero address in one cycle: port 1 wins (wd1 stored, wd0 dropped).
- Read:
  - Purely combinational from the array and pending bits.
  - Zero latency on address change.
  - All ports are independent; any number of ports may read the same address.
- Scoreboard: one pending bit per register 1..DEPTH-1.
  - Set: rsv_en && rsv_addr != 0.
  - Clear: we1 && wa1 != 0 (port 1 write to that address).
  - Port-0 writes never change pending bits.
  - Set and clear to the same address in one cycle: set wins (a newer producer was issued). Pending stays 1; the data is still written.
  - Reserving an already-pending register: stays pending (no count; at most one outstanding late op per register is guaranteed by the issue logic).
  - Port-1 write to a non-pending register: data written, bit stays 0.
- No internal state machine beyond the array and scoreboard; there is no back-pressure.

Optional Feature:
- Macro: MIPS_REG_FILE_MP_BYPASS_EN.
- Defined: write-through forwarding on every read port, so same-cycle writes are visible on rd.
  - If we1 && wa1 == ra_i && wa1 != 0: rd_i = wd1.
  - Else if we0 && wa0 == ra_i && wa0 != 0: rd_i = wd0.
  - Else: array value.
  - rd_pending_i is also forced to 0 when port 1 is forwarding to that port, unless rsv_en targets the same address that cycle.
  - Reset does not gate the bypass path.
- Undefined: the array value only; forwarding is the pipeline's job.

Decomposition:
- Package mips_rf_pkg holds:
  - Default constants RF_DW = 32, RF_DEPTH = 32.
  - typedef rf_addr_t (logic [4:0]) and rf_data_t (logic [31:0]) for core-level instantiation.
- Sub-module mips_rf_scoreboard:
  - Owns the pending-bit vector, set/clear priority and any_pending.
  - The parent instantiates it and indexes it per read port.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 on port 0; next cycle ra0 = 5 → rd0 = 0xDEADBEEF. Write 0x1234 to r0 → rd reading r0 = 0.
- Same cycle we0 r7 = 0x11, we1 r7 = 0x22 → next cycle r7 reads 0x22.
- rsv r9 → rd_pending = 1, any_pending = 1 next cycle. Port-0 write r9 → still pending. Port-1 write r9 = 0x55 → pending 0, data 0x55.
- rsv r3 and port-1 write r3 = 0xAA in the same cycle → r3 reads 0xAA, pending stays 1.
- Load r1..r31 and reserve r4, then assert rst while we0 targets r2 = 0xFF → all reads 0, any_pending = 0.
- BYPASS_EN build: we0 r6 = 0x77 with ra1 = 6 → rd1 = 0x77 in the same cycle. Without the macro → old value, 0x77 from the next cycle.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared constants and core-level types for the MIPS multi-port register file.
// Core-level instantiations use rf_addr_t / rf_data_t to stay width-consistent with the defaults.
package mips_rf_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NUM_RD = 2;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by decode reservations and
// cleared by late (port 1) writebacks; register 0 is never pending.
module mips_rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    output logic [DEPTH-1:0] pending,
    output logic             any_pending
);

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] pending_nxt;

    // A same-cycle reservation beats the clear: it stands for a newer producer.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_en && (rsv_addr != '0)) begin
            set_vec[rsv_addr] = 1'b1;
        end
        if (we1 && (wa1 != '0)) begin
            clr_vec[wa1] = 1'b1;
        end
        pending_nxt    = set_vec | (pending & ~clr_vec);
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign any_pending = |pending;

endmodule

// File: rtl/mips_reg_file_mp.sv
// Multi-port MIPS register file: NUM_RD combinational reads, ALU (port 0) and late (port 1) writes,
// pending scoreboard. Define MIPS_REG_FILE_MP_BYPASS_EN for same-cycle write-through forwarding.
module mips_reg_file_mp
    import mips_rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [DW-1:0]        wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [DW-1:0]        wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD*DW-1:0] rd,
    output logic [NUM_RD-1:0]    rd_pending,
    output logic                 any_pending
);

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             wr0_live;
    logic             wr1_live;

    assign wr0_live = we0 && (wa0 != '0);
    assign wr1_live = we1 && (wa1 != '0);

    // Port 1 is written last so it wins a same-address collision with port 0.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_live) begin
                regs[wa0] <= wd0;
            end
            if (wr1_live) begin
                regs[wa1] <= wd1;
            end
        end
    end

    mips_rf_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .CLK         (CLK),
        .rst         (rst),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .we1         (we1),
        .wa1         (wa1),
        .pending     (pending),
        .any_pending (any_pending)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] arr_data;
        logic          arr_pend;

        assign addr     = ra[p*AW +: AW];
        assign arr_data = (addr == '0) ? '0 : regs[addr];
        assign arr_pend = pending[addr];

`ifdef MIPS_REG_FILE_MP_BYPASS_EN
        logic fwd1;
        logic fwd0;
        logic rsv_same;

        assign fwd1     = wr1_live && (wa1 == addr);
        assign fwd0     = wr0_live && (wa0 == addr);
        assign rsv_same = rsv_en && (rsv_addr == addr);

        // A returning late result retires the hazard now, unless decode re-reserves it this cycle.
        assign rd[p*DW +: DW] = fwd1 ? wd1 : (fwd0 ? wd0 : arr_data);
        assign rd_pending[p]  = arr_pend && !(fwd1 && !rsv_same);
`else
        assign rd[p*DW +: DW] = arr_data;
        assign rd_pending[p]  = arr_pend;
`endif
    end

endmodule

// File: tb/tb_mips_reg_file_mp.sv
// Self-checking bench for mips_reg_file_mp: directed scenarios then random traffic,
// all checked against an array-based reference model of the register file.
module tb_mips_reg_file_mp;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                 CLK = 1'b0;
    logic                 rst;
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [DW-1:0]        wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [DW-1:0]        wd1;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic [NUM_RD*AW-1:0] ra;
    logic [NUM_RD*DW-1:0] rd;
    logic [NUM_RD-1:0]    rd_pending;
    logic                 any_pending;

    logic [DW-1:0] modelMem  [DEPTH];
    bit            modelPend [DEPTH];
    int            total = 0;
    int            bad   = 0;

    always #5 CLK = ~CLK;

    mips_reg_file_mp #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .we0         (we0),
        .wa0         (wa0),
        .wd0         (wd0),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .ra          (ra),
        .rd          (rd),
        .rd_pending  (rd_pending),
        .any_pending (any_pending)
    );

    // Drive one cycle's inputs during the low phase, well away from the rising edge.
    task automatic applyStimulus(input logic r, input logic e0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic e1, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d1, input logic rs, input logic [AW-1:0] rsa,
                                 input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        rst      = r;
        we0      = e0;
        wa0      = a0;
        wd0      = d0;
        we1      = e1;
        wa1      = a1;
        wd1      = d1;
        rsv_en   = rs;
        rsv_addr = rsa;
        ra       = {p1, p0};
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] expData;
        logic          expPend;
        logic          expAny;
        for (int i = 0; i < NUM_RD; i++) begin
            a       = ra[i*AW +: AW];
            expData = (a == 0) ? '0 : modelMem[a];
            expPend = (a == 0) ? 1'b0 : modelPend[a];
`ifdef MIPS_REG_FILE_MP_BYPASS_EN
            if (we1 && wa1 == a && a != 0) begin
                expData = wd1;
                if (!(rsv_en && rsv_addr == a)) expPend = 1'b0;
            end else if (we0 && wa0 == a && a != 0) begin
                expData = wd0;
            end
`endif
            total++;
            assert (rd[i*DW +: DW] === expData) else begin
                bad++;
                $error("[TB] FAIL %s rd%0d(r%0d) observed=%h expected=%h", tag, i, a, rd[i*DW +: DW], expData);
            end
            total++;
            assert (rd_pending[i] === expPend) else begin
                bad++;
                $error("[TB] FAIL %s rd_pending%0d(r%0d) observed=%b expected=%b", tag, i, a, rd_pending[i], expPend);
            end
        end
        expAny = 1'b0;
        for (int r = 1; r < DEPTH; r++) expAny |= modelPend[r];
        total++;
        assert (any_pending === expAny) else begin
            bad++;
            $error("[TB] FAIL %s any_pending observed=%b expected=%b", tag, any_pending, expAny);
        end
    endtask

    // Advance one clock and apply the architectural update rules to the model.
    task automatic clockEdge();
        @(posedge CLK);
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                modelMem[r]  = '0;
                modelPend[r] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) modelMem[wa0] = wd0;
            if (we1 && wa1 != 0) begin
                modelMem[wa1]  = wd1;
                modelPend[wa1] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) modelPend[rsv_addr] = 1'b1;
        end
        @(negedge CLK);
    endtask

    task automatic cycle(input string tag, input logic r, input logic e0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic e1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic rs, input logic [AW-1:0] rsa,
                         input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        applyStimulus(r, e0, a0, d0, e1, a1, d1, rs, rsa, p0, p1);
        checkOutput(tag);
        clockEdge();
    endtask

    initial begin
        logic          rr, e0, e1, rs;
        logic [AW-1:0] a0, a1, rsa, p0, p1;
        logic [DW-1:0] d0, d1;

        for (int r = 0; r < DEPTH; r++) begin
            modelMem[r]  = '0;
            modelPend[r] = 1'b0;
        end
        @(negedge CLK);
        // DUT state is unknown until the first reset edge, so that cycle is not checked.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();

        cycle("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
        cycle("wr_r5",       0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 6);
        cycle("rd_r5_wr_r0", 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
        cycle("rd_r0",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

        cycle("dual_r7",     0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
        cycle("dual_r7_rd",  0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 5);

        cycle("rsv_r9",      0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 7);
        cycle("p0_wr_r9",    0, 1, 9, 32'h44, 0, 0, 0, 0, 0, 9, 9);
        cycle("p1_wr_r9",    0, 0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 0);
        cycle("r9_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

        cycle("rsv_wr_r3",   0, 0, 0, 0, 1, 3, 32'hAA, 1, 3, 3, 9);
        cycle("r3_pending",  0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        cycle("rsv_r0",      0, 0, 0, 0, 1, 0, 32'h99, 1, 0, 0, 3);
        cycle("p1_nonpend",  0, 0, 0, 0, 1, 12, 32'hC0FFEE, 0, 0, 12, 3);

        cycle("bypass_r6",   0, 1, 6, 32'h77, 0, 0, 0, 0, 0, 5, 6);
        cycle("after_r6",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);

        for (int r = 1; r < DEPTH; r++) begin
            cycle("load_all", 0, 1, AW'(r), 32'h01010101 * r, 0, 0, 0, 0, 0, AW'(r - 1), AW'(DEPTH - r));
        end
        cycle("rsv_r4",      0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 2);
        cycle("rst_over_wr", 1, 1, 2, 32'hFF, 0, 0, 0, 0, 0, 4, 2);
        for (int r = 0; r < DEPTH; r += 2) begin
            cycle("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, AW'(r), AW'(r + 1));
        end

        // Random traffic, with collisions forced often enough to exercise the priority rules.
        for (int n = 0; n < 600; n++) begin
            rr  = ($urandom_range(0, 49) == 0);
            e0  = $urandom_range(0, 1);
            e1  = $urandom_range(0, 1);
            rs  = ($urandom_range(0, 2) == 0);
            a0  = AW'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 7));
            rsa = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 7));
            p0  = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 7));
            p1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
            d0  = $urandom;
            d1  = $urandom;
            cycle("random", rr, e0, a0, d0, e1, a1, d1, rs, rsa, p0, p1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
